core_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end with a decoupling instruction queue.

---
 rtl/core_fetch_queue_if.sv | 15 +
 rtl/core_fetch_queue.sv | 128 ++++++++++++
 tb/tb_core_fetch_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/core_fetch_queue_if.sv
// Per-lane instruction read bus between the fetch front end (master) and instruction memory (slave).
// A grant on a lane returns its read data in the same cycle.
interface core_fetch_queue_if #(
  parameter int FETCH_W = 2,
  parameter int AW      = 8,
  parameter int DW      = 16
);
  logic [FETCH_W-1:0]    mem_val;
  logic [FETCH_W*AW-1:0] mem_addr;
  logic [FETCH_W-1:0]    mem_rdy;
  logic [FETCH_W*DW-1:0] mem_rdata;

  modport master (output mem_val, mem_addr, input mem_rdy, mem_rdata);
  modport slave  (input mem_val, mem_addr, output mem_rdy, mem_rdata);
endinterface

// File: rtl/core_fetch_queue.sv
// Instruction-fetch front end: issues up to FETCH_W sequential reads per cycle into a
// DEPTH-entry circular queue that decode drains up to FETCH_W entries per cycle.
module core_fetch_queue #(
  parameter int            FETCH_W  = 2,
  parameter int            DEPTH    = 8,
  parameter int            AW       = 8,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = 'h10
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     exec_i,
  input  logic                           halt_i,
  input  logic                           redirect_i,
  input  logic [AW-1:0]                  redirect_pc_i,
  core_fetch_queue_if.master             mem,
  output logic [$clog2(FETCH_W+1)-1:0]   out_cnt_o,
  output logic [FETCH_W*DW-1:0]          out_instr_o,
  output logic [FETCH_W*AW-1:0]          out_pc_o,
  input  logic [$clog2(FETCH_W+1)-1:0]   deq_cnt_i,
  output logic [AW-1:0]                  fetch_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o
);
  localparam int CW = $clog2(FETCH_W+1);
  localparam int NW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_instr [DEPTH];
  logic [AW-1:0] r_pc    [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [NW-1:0] r_count;
  logic [AW-1:0] r_fpc;
  logic          r_enq_prev;

  logic [NW-1:0]         w_free;
  logic [FETCH_W-1:0]    w_val, w_acc;
  logic [FETCH_W*AW-1:0] w_addr;
  logic [CW-1:0]         w_n_enq, w_out_cnt, w_deq;

  // Free space ignores this cycle's dequeue so deq_cnt_i never reaches the request path.
  assign w_free = NW'(DEPTH) - r_count;

  always_comb begin
    w_val = '0;
    if (!rst_i && !redirect_i && !halt_i) begin
      if (exec_i == 2'd1) begin
        for (int k = 0; k < FETCH_W; k++) w_val[k] = (NW'(k) < w_free);
      end else if (exec_i == 2'd2) begin
        w_val[0] = (r_count == '0) && !r_enq_prev;
      end
    end
  end

  always_comb begin
    w_addr = '0;
    for (int k = 0; k < FETCH_W; k++) w_addr[k*AW +: AW] = r_fpc + AW'(k);
  end

  assign mem.mem_val  = w_val;
  assign mem.mem_addr = w_addr;

  // A lane is taken only while every lower lane has been taken (in-order prefix).
  always_comb begin
    w_acc   = '0;
    w_n_enq = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (w_val[k] && mem.mem_rdy[k] && (w_n_enq == CW'(k))) begin
        w_acc[k] = 1'b1;
        w_n_enq  = w_n_enq + 1'b1;
      end
    end
  end

  assign w_out_cnt = (r_count >= NW'(FETCH_W)) ? CW'(FETCH_W) : CW'(r_count);
  assign w_deq     = (deq_cnt_i > w_out_cnt) ? w_out_cnt : deq_cnt_i;

  always_comb begin
    out_instr_o = '0;
    out_pc_o    = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (CW'(k) < w_out_cnt) begin
        out_instr_o[k*DW +: DW] = r_instr[r_head + PW'(k)];
        out_pc_o[k*AW +: AW]    = r_pc[r_head + PW'(k)];
      end
    end
  end

  assign out_cnt_o  = w_out_cnt;
  assign fetch_pc_o = r_fpc;
  assign count_o    = r_count;
  assign empty_o    = (r_count == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fpc      <= RESET_PC;
      r_enq_prev <= 1'b0;
    end else if (redirect_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fpc      <= redirect_pc_i;
      r_enq_prev <= 1'b0;
    end else begin
      r_head     <= r_head + PW'(w_deq);
      r_tail     <= r_tail + PW'(w_n_enq);
      r_count    <= r_count + NW'(w_n_enq) - NW'(w_deq);
      r_fpc      <= r_fpc + AW'(w_n_enq);
      r_enq_prev <= (w_n_enq != '0);
    end
  end

  // Storage needs no reset: entries are only visible below out_cnt_o.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (w_acc[k]) begin
        r_instr[r_tail + PW'(k)] <= mem.mem_rdata[k*DW +: DW];
        r_pc[r_tail + PW'(k)]    <= r_fpc + AW'(k);
      end
    end
  end

  deq_le_out_a: assert property (@(posedge clk_i) disable iff (rst_i || redirect_i)
                                 deq_cnt_i <= out_cnt_o);
endmodule

// File: tb/tb_core_fetch_queue.sv
// Bench for core_fetch_queue: directed scenarios then randomized traffic, checked
// every cycle against a queue-based reference model.
module tb_core_fetch_queue;
  localparam int            FW    = 2;
  localparam int            DEPTH = 8;
  localparam int            AW    = 8;
  localparam int            DW    = 16;
  localparam logic [AW-1:0] RPC   = 8'h10;
  localparam int            CW    = $clog2(FW+1);
  localparam int            NW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    exec;
  logic          halt, redir;
  logic [AW-1:0] rpc;
  logic [CW-1:0] deq, out_cnt;
  logic [FW*DW-1:0] out_instr;
  logic [FW*AW-1:0] out_pc;
  logic [AW-1:0] fetch_pc;
  logic [NW-1:0] count;
  logic          empty;

  always #5 clk = ~clk;

  core_fetch_queue_if #(.FETCH_W(FW), .AW(AW), .DW(DW)) mbus ();

  core_fetch_queue #(.FETCH_W(FW), .DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst), .exec_i(exec), .halt_i(halt), .redirect_i(redir),
    .redirect_pc_i(rpc), .mem(mbus), .out_cnt_o(out_cnt), .out_instr_o(out_instr),
    .out_pc_o(out_pc), .deq_cnt_i(deq), .fetch_pc_o(fetch_pc), .count_o(count),
    .empty_o(empty)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return 16'hA000 + DW'(a);
  endfunction

  always_comb begin
    mbus.mem_rdata = '0;
    for (int k = 0; k < FW; k++) mbus.mem_rdata[k*DW +: DW] = memf(mbus.mem_addr[k*AW +: AW]);
  end

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_fpc;
  bit            m_prev;
  int            n_chk = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] ex, input logic h, input logic rd,
                      input logic [AW-1:0] rp, input logic [FW-1:0] rdy, input int dq_req);
    logic [FW-1:0]    e_val;
    logic [FW*AW-1:0] e_addr;
    logic [FW*DW-1:0] e_ins;
    logic [FW*AW-1:0] e_pc;
    int               oc, d, n;
    @(negedge clk);
    oc = (q.size() < FW) ? q.size() : FW;
    d  = (dq_req > oc) ? oc : dq_req;
    rst = r; exec = ex; halt = h; redir = rd; rpc = rp;
    mbus.mem_rdy = rdy; deq = CW'(d);
    #1;
    e_val = '0; e_addr = '0; e_ins = '0; e_pc = '0;
    if (!r && !rd && !h) begin
      if (ex == 2'd1) begin
        for (int k = 0; k < FW; k++) e_val[k] = (k < DEPTH - q.size());
      end else if (ex == 2'd2) begin
        e_val[0] = (q.size() == 0) && !m_prev;
      end
    end
    for (int k = 0; k < FW; k++) e_addr[k*AW +: AW] = m_fpc + AW'(k);
    for (int k = 0; k < oc; k++) begin
      e_ins[k*DW +: DW] = q[k].instr;
      e_pc[k*AW +: AW]  = q[k].pc;
    end
    chk("mem_val", 64'(mbus.mem_val), 64'(e_val));
    chk("mem_addr", 64'(mbus.mem_addr), 64'(e_addr));
    chk("out_cnt", 64'(out_cnt), 64'(oc));
    chk("out_instr", 64'(out_instr), 64'(e_ins));
    chk("out_pc", 64'(out_pc), 64'(e_pc));
    chk("fetch_pc", 64'(fetch_pc), 64'(m_fpc));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    if (r) begin
      q.delete(); m_fpc = RPC; m_prev = 0;
    end else if (rd) begin
      q.delete(); m_fpc = rp; m_prev = 0;
    end else begin
      for (int i = 0; i < d; i++) void'(q.pop_front());
      n = 0;
      for (int k = 0; k < FW; k++) begin
        if (e_val[k] && rdy[k] && n == k) begin
          q.push_back('{instr: memf(m_fpc + AW'(k)), pc: m_fpc + AW'(k)});
          n++;
        end
      end
      m_fpc  = m_fpc + AW'(n);
      m_prev = (n > 0);
    end
  endtask

  initial begin
    int pr, dq;
    logic [1:0] ex;
    rst = 1'b1; exec = 2'd0; halt = 1'b0; redir = 1'b0; rpc = '0;
    mbus.mem_rdy = '0; deq = '0;
    repeat (2) @(posedge clk);
    q.delete(); m_fpc = RPC; m_prev = 0;

    // fill to full without draining, then free two slots
    for (int i = 0; i < 6; i++) step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 2);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);

    // partial grants
    step(0, 2'd1, 0, 1, 8'h20, 2'b11, 0);
    step(0, 2'd1, 0, 0, 8'h00, 2'b10, 0);
    step(0, 2'd1, 0, 0, 8'h00, 2'b01, 0);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 1);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);

    // redirect with occupancy and a requested dequeue
    step(0, 2'd1, 0, 1, 8'h40, 2'b11, 2);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);

    // address wrap
    step(0, 2'd1, 0, 1, 8'hFE, 2'b11, 0);
    for (int i = 0; i < 4; i++) step(0, 2'd1, 0, 0, 8'h00, 2'b11, 1);

    // single step, hold, halt
    step(0, 2'd2, 0, 1, 8'h30, 2'b11, 0);
    for (int i = 0; i < 3; i++) step(0, 2'd2, 0, 0, 8'h00, 2'b11, 0);
    step(0, 2'd2, 0, 0, 8'h00, 2'b11, 1);
    for (int i = 0; i < 3; i++) step(0, 2'd2, 0, 0, 8'h00, 2'b11, 0);
    step(0, 2'd1, 1, 0, 8'h00, 2'b11, 0);
    step(0, 2'd1, 1, 0, 8'h00, 2'b11, 0);

    // reset mid-operation
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);
    step(1, 2'd1, 0, 0, 8'h00, 2'b11, 0);
    step(0, 2'd1, 0, 0, 8'h00, 2'b11, 0);

    for (int i = 0; i < 3000; i++) begin
      pr = $urandom_range(0, 99);
      ex = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      if ((i % 200) < 100) dq = $urandom_range(0, FW);
      else dq = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FW) : 0;
      step(pr < 2, ex, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom), FW'($urandom), dq);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
